// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared types and constants for the signed-binary to BCD
//             conversion slice (controller + double-dabble step).
//  Contents : state_t FSM encoding, datapath widths, add-3 constants,
//             calc_ndig helper (significant-digit count of a packed BCD word).
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int BIN_W  = 15;          // magnitude width = iterations per conversion
    localparam int DIGITS = 5;           // BCD digits produced
    localparam int BCD_W  = 4 * DIGITS;  // packed BCD width
    localparam int CNT_W  = 4;           // ceil(log2(BIN_W))

    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FMT   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index of the highest nonzero digit + 1; an all-zero word still shows
    // one digit so the display never goes blank.
    function automatic logic [2:0] calc_ndig(input logic [BCD_W-1:0] bcd);
        logic [2:0] n;
        n = 3'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                n = 3'(i + 1);
            end
        end
        return n;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_dabble_step.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_dabble_step
//  Purpose  : One combinational double-dabble iteration: every digit >= 5
//             gets +3 (4-bit, no carry out), then the accumulator shifts left
//             by one with shift_in entering bit 0.
//  Ports    : acc_in   [BCD_W-1:0]  current BCD accumulator
//             shift_in              next magnitude bit (MSB first)
//             acc_out  [BCD_W-1:0]  accumulator after this iteration
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_dabble_step
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] acc_in,
    input  logic             shift_in,
    output logic [BCD_W-1:0] acc_out
);

    logic [BCD_W-1:0] w_adj;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            logic [3:0] w_dig;
            assign w_dig            = acc_in[4*g +: 4];
            assign w_adj[4*g +: 4]  = (w_dig >= ADD3_THRESH) ? (w_dig + ADD3_VAL) : w_dig;
        end
    endgenerate

    // Top bit of the adjusted word is dropped: for magnitudes <= 32767 the
    // upper digit never exceeds 3 before the final shift, so nothing is lost.
    assign acc_out = {w_adj[BCD_W-2:0], shift_in};

endmodule : bcd_dabble_step
`default_nettype wire

// File: rtl/bcd_conv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_conv_ctrl
//  Purpose  : Converts a signed 16-bit product into sign + packed BCD, one
//             double-dabble iteration per clock, with valid/ready handshakes
//             on both sides.
//  Ports    : clk, rst_n (async active-low), clr (sync abort)
//             in_valid / in_ready / in_data[15:0]   input handshake
//             out_valid / out_ready                 output handshake
//             out_bcd[19:0]  digit 0 in [3:0]
//             out_neg        input negative and nonzero
//             out_ndig[2:0]  significant digits, 1..5
//             out_ovf        input was -32768 (out_bcd forced to 0)
//             busy           FSM not in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_conv_ctrl
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BCD_W-1:0] out_bcd,
    output logic             out_neg,
    output logic [2:0]       out_ndig,
    output logic             out_ovf,
    output logic             busy
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [BIN_W-1:0] r_mag;
    logic             r_neg;
    logic             r_ovf;
    logic [BCD_W-1:0] r_acc;

    logic [15:0]      w_abs;
    logic [CNT_W-1:0] w_idx;
    logic             w_shift_bit;
    logic [BCD_W-1:0] w_acc_next;

    // Magnitude of -32768 does not fit in 15 bits; its low 15 bits are zero,
    // which is harmless because ovf forces the result anyway.
    assign w_abs       = in_data[15] ? (16'd0 - in_data) : in_data;
    assign w_idx       = CNT_W'(BIN_W - 1) - r_cnt;
    assign w_shift_bit = r_mag[w_idx];

    bcd_dabble_step u_step (
        .acc_in   (r_acc),
        .shift_in (w_shift_bit),
        .acc_out  (w_acc_next)
    );

    assign in_ready  = (r_state == IDLE) && !clr;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mag    <= '0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_acc    <= '0;
            out_bcd  <= '0;
            out_neg  <= 1'b0;
            out_ndig <= 3'd1;
            out_ovf  <= 1'b0;
        end else if (clr) begin
            // Abort: in-flight work is dropped, last published result is kept.
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mag   <= w_abs[BIN_W-1:0];
                        r_neg   <= in_data[15] && (in_data != 16'd0);
                        r_ovf   <= (in_data == 16'h8000);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(BIN_W - 1)) begin
                        r_state <= FMT;
                    end
                end
                FMT: begin
                    if (r_ovf) begin
                        out_bcd  <= '0;
                        out_ndig <= 3'd1;
                        out_neg  <= 1'b1;
                    end else begin
                        out_bcd  <= r_acc;
                        out_ndig <= calc_ndig(r_acc);
                        out_neg  <= r_neg;
                    end
                    out_ovf <= r_ovf;
                    r_state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : bcd_conv_ctrl
`default_nettype wire

// File: tb/tb_bcd_conv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_conv_ctrl
//  Purpose  : Directed self-checking bench for bcd_conv_ctrl. Expected values
//             are hand-computed constants in the stimulus calls.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_conv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_bcd;
    logic        out_neg;
    logic [2:0]  out_ndig;
    logic        out_ovf;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_acc_cyc = 0;

    bcd_conv_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_neg   (out_neg),
        .out_ndig  (out_ndig),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One conversion. hold = cycles out_ready stays low once out_valid rises.
    // gap_exp > 0 checks the accept-to-accept spacing from the previous call.
    task automatic do_conv(input string tag, input logic [15:0] d,
                           input logic [19:0] e_bcd, input logic e_neg,
                           input logic [2:0] e_ndig, input logic e_ovf,
                           input int hold, input int gap_exp);
        int n;
        int acc_cyc;
        logic [19:0] snap;
        @(negedge clk);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check_eq({tag, ".in_ready_idle"}, in_ready, 1);
        @(posedge clk);               // accept edge E0
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        if (gap_exp > 0) check_eq({tag, ".gap"}, acc_cyc - last_acc_cyc, gap_exp);
        last_acc_cyc = acc_cyc;
        check_eq({tag, ".in_ready_busy"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        // FMT loads on the 16th edge after accept -> valid in the 17th cycle
        check_eq({tag, ".latency"}, n, 16);
        check_eq({tag, ".bcd"},  out_bcd,  e_bcd);
        check_eq({tag, ".neg"},  out_neg,  e_neg);
        check_eq({tag, ".ndig"}, out_ndig, e_ndig);
        check_eq({tag, ".ovf"},  out_ovf,  e_ovf);
        snap = out_bcd;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, ".hold_valid"}, out_valid, 1);
            check_eq({tag, ".hold_bcd"}, out_bcd, snap);
            check_eq({tag, ".hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);               // output handshake edge
        #1;
        check_eq({tag, ".valid_drop"}, out_valid, 0);
        check_eq({tag, ".in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst.in_ready",  in_ready,  1);
        check_eq("rst.out_valid", out_valid, 0);
        check_eq("rst.bcd",       out_bcd,   0);
        check_eq("rst.neg",       out_neg,   0);
        check_eq("rst.ndig",      out_ndig,  1);
        check_eq("rst.ovf",       out_ovf,   0);
        check_eq("rst.busy",      busy,      0);

        do_conv("zero",   16'd0,     20'h00000, 0, 3'd1, 0, 0, 0);
        do_conv("p16384", 16'h4000,  20'h16384, 0, 3'd5, 0, 0, 18);
        do_conv("m16256", 16'hC080,  20'h16256, 1, 3'd5, 0, 0, 18);
        do_conv("m7",     16'hFFF9,  20'h00007, 1, 3'd1, 0, 0, 18);
        do_conv("m32768", 16'h8000,  20'h00000, 1, 3'd1, 1, 0, 18);
        do_conv("p32767", 16'h7FFF,  20'h32767, 0, 3'd5, 0, 0, 18);
        do_conv("p123",   16'd123,   20'h00123, 0, 3'd3, 0, 10, 0);

        // Abort on the 7th SHIFT cycle (cycle after the 6th edge past accept)
        @(negedge clk);
        in_data = 16'd9876; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("clr.busy_before", busy, 1);
        clr = 1'b1;
        check_eq("clr.in_ready_gated", in_ready, 0);
        @(posedge clk);
        #1;
        check_eq("clr.busy_after", busy, 0);
        clr = 1'b0;
        #1;
        check_eq("clr.in_ready", in_ready, 1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1 if (out_valid) seen++;
            end
            check_eq("clr.no_valid", seen, 0);
        end
        check_eq("clr.bcd_retained", out_bcd, 20'h00123);
        do_conv("p42", 16'd42, 20'h00042, 0, 3'd2, 0, 0, 0);

        // Asynchronous reset in the middle of SHIFT
        @(negedge clk);
        in_data = 16'h7FFF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst.busy",      busy,      0);
        check_eq("arst.out_valid", out_valid, 0);
        check_eq("arst.bcd",       out_bcd,   0);
        check_eq("arst.ndig",      out_ndig,  1);
        check_eq("arst.neg",       out_neg,   0);
        check_eq("arst.ovf",       out_ovf,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst.in_ready", in_ready, 1);
        do_conv("post_rst", 16'hFFFF, 20'h00001, 1, 3'd1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_bcd_conv_ctrl
`default_nettype wire
